// File: rtl/gd_xfer_sequencer.sv
// Data-phase sequencer for GD-ROM packet commands: pulls words from the
// sector FIFO and hands them to the IDE side in PIO or DMA mode, driving
// BSY/DRQ, IO/CoD, byte count and INTRQ requests, chunked per DRQ block.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | no transfer, status idle, waits for start
// LOAD      | size the next chunk, publish byte_count
// PREFETCH  | wait for a FIFO word, pop it
// CAPTURE   | popped word lands in data_word, raise DRQ/DMARQ (+INTRQ)
// ANNOUNCE  | one-cycle settle while the host sees the new block
// XFER      | host strobes consume words, refill from FIFO
// FINISH    | completion status, INTRQ and done pulses
module gd_xfer_sequencer #(
  parameter int CHUNK_BYTES = 2048,
  parameter int WORD_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              dma_mode,
  input  logic [15:0]       xfer_bytes,
  input  logic              fifo_empty,
  input  logic [WORD_W-1:0] fifo_rdata,
  output logic              fifo_rd,
  input  logic              host_strobe,
  output logic [WORD_W-1:0] data_word,
  output logic [15:0]       byte_count,
  output logic              bsy,
  output logic              drq,
  output logic              io,
  output logic              cod,
  output logic              dmarq,
  output logic              intrq_set,
  output logic              underrun,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_PREFETCH, S_CAPTURE, S_ANNOUNCE, S_XFER, S_FINISH
  } state_t;

  localparam logic [15:0] CHUNK = CHUNK_BYTES[15:0];

  state_t      state;
  logic        dma;
  logic [15:0] remaining;
  logic [15:0] chunk_left;
  logic        word_valid;
  logic        rd_pending;
  logic [15:0] rem_next;
  logic [15:0] chunk_next;
  logic        last_word;

  assign rem_next   = (remaining  >= 16'd2) ? remaining  - 16'd2 : 16'd0;
  assign chunk_next = (chunk_left >= 16'd2) ? chunk_left - 16'd2 : 16'd0;
  assign last_word  = (chunk_left <= 16'd2);

  // FIFO pop: gated by fifo_empty here so a pop can never hit an empty FIFO.
  // In XFER a strobe on a valid word pops its successor unless the chunk
  // ends; a starved word slot refetches on its own once data shows up.
  always_comb begin
    fifo_rd = 1'b0;
    if (!fifo_empty) begin
      case (state)
        S_PREFETCH: fifo_rd = 1'b1;
        S_XFER: begin
          if (host_strobe && word_valid && !last_word)
            fifo_rd = 1'b1;
          else if (!word_valid && !rd_pending && !(host_strobe && last_word))
            fifo_rd = 1'b1;
        end
        default: fifo_rd = 1'b0;
      endcase
    end
  end

  // Sequencer FSM with registered status/handshake outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      dma        <= 1'b0;
      remaining  <= 16'd0;
      chunk_left <= 16'd0;
      word_valid <= 1'b0;
      rd_pending <= 1'b0;
      data_word  <= '0;
      byte_count <= 16'd0;
      bsy        <= 1'b0;
      drq        <= 1'b0;
      io         <= 1'b1;
      cod        <= 1'b1;
      dmarq      <= 1'b0;
      intrq_set  <= 1'b0;
      underrun   <= 1'b0;
      done       <= 1'b0;
    end else begin
      intrq_set  <= 1'b0;
      done       <= 1'b0;
      rd_pending <= fifo_rd;
      case (state)
        S_IDLE: begin
          if (start) begin
            dma       <= dma_mode;
            remaining <= xfer_bytes & 16'hFFFE;
            underrun  <= 1'b0;
            if ((xfer_bytes & 16'hFFFE) == 16'd0) begin
              intrq_set <= 1'b1;
              done      <= 1'b1;
              state     <= S_FINISH;
            end else begin
              bsy   <= 1'b1;
              state <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          chunk_left <= (remaining < CHUNK) ? remaining : CHUNK;
          byte_count <= (remaining < CHUNK) ? remaining : CHUNK;
          state      <= S_PREFETCH;
        end
        S_PREFETCH: begin
          if (!fifo_empty) state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          data_word  <= fifo_rdata;
          word_valid <= 1'b1;
          bsy        <= 1'b0;
          drq        <= 1'b1;
          io         <= 1'b1;
          cod        <= 1'b0;
          dmarq      <= dma;
          intrq_set  <= !dma;
          state      <= S_ANNOUNCE;
        end
        S_ANNOUNCE: state <= S_XFER;
        S_XFER: begin
          // A word arriving this cycle wins over a starve decision below.
          if (rd_pending) begin
            data_word  <= fifo_rdata;
            word_valid <= 1'b1;
            dmarq      <= dma;
          end
          if (host_strobe) begin
            remaining  <= rem_next;
            chunk_left <= chunk_next;
            if (!word_valid) underrun <= 1'b1;
            if (last_word) begin
              drq        <= 1'b0;
              dmarq      <= 1'b0;
              word_valid <= 1'b0;
              if (rem_next == 16'd0) begin
                cod       <= 1'b1;
                intrq_set <= 1'b1;
                done      <= 1'b1;
                state     <= S_FINISH;
              end else begin
                bsy   <= 1'b1;
                state <= S_LOAD;
              end
            end else if (word_valid && fifo_empty && !rd_pending) begin
              word_valid <= 1'b0;
              dmarq      <= 1'b0;
            end
          end
        end
        S_FINISH: begin
          byte_count <= 16'd0;
          data_word  <= '0;
          word_valid <= 1'b0;
          bsy        <= 1'b0;
          drq        <= 1'b0;
          io         <= 1'b1;
          cod        <= 1'b1;
          dmarq      <= 1'b0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gd_xfer_sequencer.sv
// Self-checking bench for gd_xfer_sequencer: FIFO model, host model and
// scoreboards for data words and announced byte counts.
module tb_gd_xfer_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        dma_mode = 1'b0;
  logic [15:0] xfer_bytes = 16'd0;
  logic        fifo_empty = 1'b1;
  logic [15:0] fifo_rdata = 16'd0;
  logic        fifo_rd;
  logic        host_strobe = 1'b0;
  logic [15:0] data_word;
  logic [15:0] byte_count;
  logic        bsy, drq, io, cod, dmarq, intrq_set, underrun, done;

  int checks = 0;
  int errors = 0;

  logic [15:0] fifo_q[$];
  logic [15:0] exp_words[$];
  logic [15:0] exp_bc[$];
  logic [15:0] obs_bc[$];

  int n_intrq, n_done, n_fiford, n_bad_rd, n_bsy_drq, n_gap_bsy, n_dmarq_fall;
  logic fin_io, fin_cod, prev_drq, prev_dmarq;

  gd_xfer_sequencer #(.CHUNK_BYTES(2048), .WORD_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .dma_mode(dma_mode),
    .xfer_bytes(xfer_bytes), .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata),
    .fifo_rd(fifo_rd), .host_strobe(host_strobe), .data_word(data_word),
    .byte_count(byte_count), .bsy(bsy), .drq(drq), .io(io), .cod(cod),
    .dmarq(dmarq), .intrq_set(intrq_set), .underrun(underrun), .done(done)
  );

  always #5 clk = ~clk;

  // FIFO model: head word valid the cycle after the pop.
  always @(posedge clk) begin
    logic [15:0] w;
    if (fifo_rd && fifo_q.size() > 0) begin
      w = fifo_q.pop_front();
      fifo_rdata <= w;
    end
  end

  // Monitor sampled on the falling edge; fifo_empty refreshed last.
  always @(negedge clk) begin
    if (intrq_set) n_intrq++;
    if (done) begin n_done++; fin_io = io; fin_cod = cod; end
    if (fifo_rd) n_fiford++;
    if (fifo_rd && fifo_empty) n_bad_rd++;
    if (bsy && drq) n_bsy_drq++;
    if (drq && !prev_drq) obs_bc.push_back(byte_count);
    if (!drq && prev_drq && bsy) n_gap_bsy++;
    if (!dmarq && prev_dmarq) n_dmarq_fall++;
    prev_drq = drq;
    prev_dmarq = dmarq;
    fifo_empty = (fifo_q.size() == 0);
  end

  task automatic clear_mon();
    n_intrq = 0; n_done = 0; n_fiford = 0; n_bad_rd = 0;
    n_bsy_drq = 0; n_gap_bsy = 0; n_dmarq_fall = 0;
    obs_bc.delete();
  endtask

  task automatic push_word(input logic [15:0] w);
    fifo_q.push_back(w);
    exp_words.push_back(w);
  endtask

  task automatic pulse_start(input logic dm, input logic [15:0] len);
    @(posedge clk); #1 start = 1'b1; dma_mode = dm; xfer_bytes = len;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic strobe();
    @(posedge clk); #1 host_strobe = 1'b1;
    @(posedge clk); #1 host_strobe = 1'b0;
  endtask

  task automatic read_word(input logic dm);
    int i;
    logic [15:0] e;
    i = 0;
    while (((dm ? dmarq : drq) !== 1'b1) && i < 80) begin
      @(negedge clk); i++;
    end
    checks++;
    if (i >= 80) begin
      errors++;
      $display("FAIL read_wait: handshake got 0 required 1");
    end else if (exp_words.size() == 0) begin
      errors++;
      $display("FAIL scoreboard: word presented with no expected word queued");
    end else begin
      e = exp_words.pop_front();
      if (data_word !== e) begin
        errors++;
        $display("FAIL data_word: got %h required %h", data_word, e);
      end
    end
    strobe();
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_done();
    int i;
    i = 0;
    while (n_done == 0 && i < 100) begin @(negedge clk); i++; end
    checks++;
    if (n_done == 0) begin
      errors++;
      $display("FAIL done_wait: done count 0 required 1");
    end
    @(negedge clk);
  endtask

  task automatic check_bc();
    logic [15:0] e, o;
    while (exp_bc.size() > 0) begin
      e = exp_bc.pop_front();
      checks++;
      if (obs_bc.size() == 0) begin
        errors++;
        $display("FAIL byte_count: no block announced, required %0d", e);
      end else begin
        o = obs_bc.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL byte_count: got %0d required %0d", o, e);
        end
      end
    end
    checks++;
    if (obs_bc.size() != 0) begin
      errors++;
      $display("FAIL byte_count_extra: %0d extra blocks announced, required 0", obs_bc.size());
    end
  endtask

  task automatic check_int(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, got, req);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_int("rst_bsy", bsy, 0);
    check_int("rst_drq", drq, 0);
    check_int("rst_io_cod", {io, cod}, 3);
    check_int("rst_dmarq", dmarq, 0);
    check_int("rst_pulses", {intrq_set, done, fifo_rd, underrun}, 0);
    check_int("rst_bc_data", {byte_count, data_word}, 0);
    #1 reset = 1'b0;
  endtask

  task automatic test_pio_basic();
    int i;
    clear_mon();
    for (int k = 0; k < 6; k++) push_word(16'hA100 + 16'(k));
    exp_bc.push_back(16'd12);
    pulse_start(1'b0, 16'd12);
    @(negedge clk);
    check_int("pio_bsy_load", bsy, 1);
    i = 0;
    while (drq !== 1'b1 && i < 20) begin @(negedge clk); i++; end
    check_int("pio_announce_intrq", intrq_set, 1);
    check_int("pio_announce_io_cod", {io, cod}, 2);
    check_int("pio_announce_bsy", bsy, 0);
    for (int k = 0; k < 6; k++) read_word(1'b0);
    wait_done();
    check_int("pio_intrq_count", n_intrq, 2);
    check_int("pio_done_count", n_done, 1);
    check_int("pio_finish_io_cod", {fin_io, fin_cod}, 3);
    check_int("pio_bsy_with_drq", n_bsy_drq, 0);
    check_int("pio_bad_rd", n_bad_rd, 0);
    check_int("pio_pops", n_fiford, 6);
    check_bc();
  endtask

  task automatic test_chunking();
    clear_mon();
    for (int k = 0; k < 2500; k++) push_word(16'(k * 7));
    exp_bc.push_back(16'd2048);
    exp_bc.push_back(16'd2048);
    exp_bc.push_back(16'd904);
    pulse_start(1'b0, 16'd5000);
    for (int k = 0; k < 2500; k++) read_word(1'b0);
    wait_done();
    check_bc();
    check_int("chunk_intrq_count", n_intrq, 4);
    check_int("chunk_bsy_between", n_gap_bsy, 2);
    check_int("chunk_bsy_with_drq", n_bsy_drq, 0);
    check_int("chunk_underrun", underrun, 0);
  endtask

  task automatic test_dma_trickle();
    clear_mon();
    exp_bc.push_back(16'd8);
    pulse_start(1'b1, 16'd8);
    fork
      begin
        repeat (15) @(negedge clk);
        check_int("dma_no_req_empty", {dmarq, drq}, 0);
        for (int k = 0; k < 4; k++) begin
          @(posedge clk); #1 push_word(16'hD000 + 16'(k));
          repeat (9) @(posedge clk);
        end
      end
      begin
        for (int k = 0; k < 4; k++) read_word(1'b1);
      end
    join
    wait_done();
    check_int("dma_intrq_count", n_intrq, 1);
    check_int("dma_done_count", n_done, 1);
    check_int("dma_starve_drops", n_dmarq_fall, 4);
    check_int("dma_underrun", underrun, 0);
    check_int("dma_bad_rd", n_bad_rd, 0);
    check_bc();
  endtask

  task automatic test_underrun();
    int i;
    clear_mon();
    push_word(16'h5A5A);
    exp_bc.push_back(16'd4);
    pulse_start(1'b0, 16'd4);
    i = 0;
    while (drq !== 1'b1 && i < 20) begin @(negedge clk); i++; end
    check_int("ur_first_word", data_word, 16'h5A5A);
    void'(exp_words.pop_front());
    @(posedge clk); #1 host_strobe = 1'b1;
    @(posedge clk); @(posedge clk); #1 host_strobe = 1'b0;
    wait_done();
    check_int("ur_flag", underrun, 1);
    check_int("ur_done_count", n_done, 1);
    check_int("ur_bad_rd", n_bad_rd, 0);
    check_bc();
  endtask

  task automatic test_zero_len();
    clear_mon();
    pulse_start(1'b0, 16'd1);
    @(negedge clk);
    check_int("zero_done", done, 1);
    check_int("zero_intrq", intrq_set, 1);
    check_int("zero_underrun_cleared", underrun, 0);
    repeat (3) @(negedge clk);
    check_int("zero_no_rd", n_fiford, 0);
    check_int("zero_done_count", n_done, 1);
  endtask

  task automatic test_busy_start();
    clear_mon();
    push_word(16'h1111);
    push_word(16'h2222);
    exp_bc.push_back(16'd4);
    pulse_start(1'b0, 16'd4);
    read_word(1'b0);
    pulse_start(1'b1, 16'd100);
    read_word(1'b0);
    wait_done();
    repeat (5) @(negedge clk);
    check_int("busy_done_count", n_done, 1);
    check_int("busy_intrq_count", n_intrq, 2);
    check_int("busy_idle_after", {bsy, drq, dmarq}, 0);
    check_bc();
  endtask

  task automatic test_reset_mid();
    clear_mon();
    for (int k = 0; k < 6; k++) push_word(16'hC300 + 16'(k));
    pulse_start(1'b0, 16'd12);
    for (int k = 0; k < 3; k++) read_word(1'b0);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check_int("mid_rst_status", {bsy, drq, io, cod}, 4'b0011);
    repeat (4) @(negedge clk);
    check_int("mid_rst_no_done", n_done, 0);
    check_int("mid_rst_fifo_left", fifo_q.size(), 2);
    check_int("mid_rst_pops", n_fiford, 4);
    fifo_q.delete();
    exp_words.delete();
  endtask

  initial begin
    clear_mon();
    prev_drq = 1'b0;
    prev_dmarq = 1'b0;
    fin_io = 1'b0;
    fin_cod = 1'b0;
    test_reset();
    test_pio_basic();
    test_chunking();
    test_dma_trickle();
    test_underrun();
    test_zero_len();
    test_busy_start();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
